// File: rtl/ws_pe_pkg.sv
// rtl/ws_pe_pkg.sv - shared widths and saturating-add helper for the weight-stationary PE
package ws_pe_pkg;

   localparam int DEFAULT_DATA_WIDTH = 16;
   localparam int DEFAULT_PSUM_WIDTH = 32;
   localparam int MUL_STAGES_MAX     = 2;
   localparam int SAT_MAX_WIDTH      = 64;

   typedef struct packed {
      logic        sat;
      logic [63:0] sum;
   } sat_res_t;

   // Operands are pw-bit values carried in the low bits; result is clamped to the pw-bit range.
   function automatic sat_res_t sat_add(input logic [63:0] a, input logic [63:0] b,
                                        input int unsigned pw, input logic sgn);
      logic [63:0] mask;
      logic [63:0] msb;
      logic [63:0] hi;
      logic [64:0] ae;
      logic [64:0] be;
      logic [64:0] s;
      sat_res_t    r;
      mask = (pw >= 64) ? '1 : ((64'd1 << pw) - 64'd1);
      msb  = mask & ~(mask >> 1);
      hi   = mask >> 1;
      ae   = {1'b0, a & mask};
      be   = {1'b0, b & mask};
      if (sgn) begin
         if ((a & msb) != 64'd0) ae = ae | ~{1'b0, mask};
         if ((b & msb) != 64'd0) be = be | ~{1'b0, mask};
      end
      s     = ae + be;
      r.sat = 1'b0;
      r.sum = s[63:0] & mask;
      if (sgn) begin
         if ($signed(s) > $signed({1'b0, hi})) begin
            r.sat = 1'b1;
            r.sum = hi;
         end else if ($signed(s) < $signed(~{1'b0, hi})) begin
            r.sat = 1'b1;
            r.sum = msb;
         end
      end else if (s > {1'b0, mask}) begin
         r.sat = 1'b1;
         r.sum = mask;
      end
      return r;
   endfunction

endpackage

// File: rtl/ws_pe_weight_buf.sv
// rtl/ws_pe_weight_buf.sv - shadow/active weight pair; shadow forms the column shift chain
module ws_pe_weight_buf
   import ws_pe_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] weight_in,
   input  logic                  weight_shift,
   input  logic                  weight_swap,
   output logic [DATA_WIDTH-1:0] weight_shadow,
   output logic [DATA_WIDTH-1:0] weight_active
);

   // Both registers sample pre-edge values, so a same-cycle swap takes the old shadow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         weight_shadow <= '0;
         weight_active <= '0;
      end else begin
         if (weight_shift) weight_shadow <= weight_in;
         if (weight_swap)  weight_active <= weight_shadow;
      end
   end

endmodule

// File: rtl/ws_pe_dbuf.sv
// rtl/ws_pe_dbuf.sv - weight-stationary MAC PE with double-buffered weights
// Define WS_PE_SAT_EN for a saturating final add with sticky sat_flag.
module ws_pe_dbuf
   import ws_pe_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int PSUM_WIDTH = DEFAULT_PSUM_WIDTH,
   parameter int MUL_STAGES = 1,
   parameter int SIGNED     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] input_in,
   input  logic [PSUM_WIDTH-1:0] psum_in,
   output logic [DATA_WIDTH-1:0] input_out,
   output logic                  valid_out,
   output logic [PSUM_WIDTH-1:0] psum_out,
   output logic                  psum_valid,
   input  logic [DATA_WIDTH-1:0] weight_in,
   input  logic                  weight_shift,
   output logic [DATA_WIDTH-1:0] weight_out,
   input  logic                  weight_swap,
   output logic                  sat_flag
);

   localparam int PROD_W = 2 * DATA_WIDTH;
   localparam int EXT_W  = PSUM_WIDTH - PROD_W;

   generate
      if (PSUM_WIDTH < PROD_W) begin : g_bad_psum_width
         $error("ws_pe_dbuf: PSUM_WIDTH must be >= 2*DATA_WIDTH");
      end
      if (MUL_STAGES < 1 || MUL_STAGES > MUL_STAGES_MAX) begin : g_bad_mul_stages
         $error("ws_pe_dbuf: MUL_STAGES must be 1 or 2");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] w_active;

   ws_pe_weight_buf #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_weight_buf (
      .clk          (clk),
      .reset        (reset),
      .weight_in    (weight_in),
      .weight_shift (weight_shift),
      .weight_swap  (weight_swap),
      .weight_shadow(weight_out),
      .weight_active(w_active)
   );

   // Extending to the full product width first makes the low 2*DW bits exact for both signednesses.
   logic [PROD_W-1:0]     x_ext;
   logic [PROD_W-1:0]     w_ext;
   logic [PROD_W-1:0]     prod;
   logic [PSUM_WIDTH-1:0] prod_ext;

   assign x_ext = (SIGNED != 0) ? {{DATA_WIDTH{input_in[DATA_WIDTH-1]}}, input_in}
                                : {{DATA_WIDTH{1'b0}}, input_in};
   assign w_ext = (SIGNED != 0) ? {{DATA_WIDTH{w_active[DATA_WIDTH-1]}}, w_active}
                                : {{DATA_WIDTH{1'b0}}, w_active};
   assign prod  = x_ext * w_ext;

   generate
      if (EXT_W == 0) begin : g_prod_noext
         assign prod_ext = prod;
      end else begin : g_prod_ext
         assign prod_ext = {{EXT_W{(SIGNED != 0) && prod[PROD_W-1]}}, prod};
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         input_out <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= valid_in;
         if (valid_in) input_out <= input_in;
      end
   end

   logic [PSUM_WIDTH-1:0] add_a;
   logic [PSUM_WIDTH-1:0] add_b;
   logic                  add_en;

   generate
      if (MUL_STAGES == 1) begin : g_mac1
         assign add_a  = psum_in;
         assign add_b  = prod_ext;
         assign add_en = valid_in;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) psum_valid <= 1'b0;
            else       psum_valid <= valid_in;
         end
      end else begin : g_mac2
         logic [PSUM_WIDTH-1:0] psum_d;
         logic [PSUM_WIDTH-1:0] prod_r;
         logic                  v1;

         // Product is captured at issue, so a later swap cannot disturb an op in flight.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               psum_d     <= '0;
               prod_r     <= '0;
               v1         <= 1'b0;
               psum_valid <= 1'b0;
            end else begin
               v1         <= valid_in;
               psum_valid <= v1;
               if (valid_in) begin
                  psum_d <= psum_in;
                  prod_r <= prod_ext;
               end
            end
         end

         assign add_a  = psum_d;
         assign add_b  = prod_r;
         assign add_en = v1;
      end
   endgenerate

   logic [PSUM_WIDTH-1:0] sum;

`ifdef WS_PE_SAT_EN
   generate
      if (PSUM_WIDTH > SAT_MAX_WIDTH) begin : g_bad_sat_width
         $error("ws_pe_dbuf: saturation supports PSUM_WIDTH up to 64");
      end
   endgenerate

   sat_res_t sat_r;

   always_comb begin
      sat_r = sat_add(64'(add_a), 64'(add_b), PSUM_WIDTH, SIGNED != 0);
   end

   assign sum = sat_r.sum[PSUM_WIDTH-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                    sat_flag <= 1'b0;
      else if (add_en && sat_r.sat) sat_flag <= 1'b1;
   end
`else
   assign sum      = add_a + add_b;
   assign sat_flag = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       psum_out <= '0;
      else if (add_en) psum_out <= sum;
   end

endmodule

// File: tb/tb_ws_pe_dbuf.sv
// tb/tb_ws_pe_dbuf.sv - directed vector bench for ws_pe_dbuf (signed/unsigned, 1 and 2 stages)
module tb_ws_pe_dbuf;

`ifdef WS_PE_SAT_EN
   localparam logic SAT = 1'b1;
`else
   localparam logic SAT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [15:0] input_in;
   logic [31:0] psum_in;
   logic [15:0] weight_in;
   logic        weight_shift;
   logic        weight_swap;

   logic [15:0] a_input_out, b_input_out, u_input_out;
   logic        a_valid_out, b_valid_out, u_valid_out;
   logic [31:0] a_psum_out, b_psum_out, u_psum_out;
   logic        a_psum_valid, b_psum_valid, u_psum_valid;
   logic [15:0] a_weight_out, b_weight_out, u_weight_out;
   logic        a_sat_flag, b_sat_flag, u_sat_flag;

   always #5 clk = ~clk;

   ws_pe_dbuf #(.DATA_WIDTH(16), .PSUM_WIDTH(32), .MUL_STAGES(1), .SIGNED(1)) dut_a (
      .clk(clk), .reset(reset), .valid_in(valid_in), .input_in(input_in), .psum_in(psum_in),
      .input_out(a_input_out), .valid_out(a_valid_out), .psum_out(a_psum_out),
      .psum_valid(a_psum_valid), .weight_in(weight_in), .weight_shift(weight_shift),
      .weight_out(a_weight_out), .weight_swap(weight_swap), .sat_flag(a_sat_flag));

   ws_pe_dbuf #(.DATA_WIDTH(16), .PSUM_WIDTH(32), .MUL_STAGES(2), .SIGNED(1)) dut_b (
      .clk(clk), .reset(reset), .valid_in(valid_in), .input_in(input_in), .psum_in(psum_in),
      .input_out(b_input_out), .valid_out(b_valid_out), .psum_out(b_psum_out),
      .psum_valid(b_psum_valid), .weight_in(weight_in), .weight_shift(weight_shift),
      .weight_out(b_weight_out), .weight_swap(weight_swap), .sat_flag(b_sat_flag));

   ws_pe_dbuf #(.DATA_WIDTH(16), .PSUM_WIDTH(32), .MUL_STAGES(1), .SIGNED(0)) dut_u (
      .clk(clk), .reset(reset), .valid_in(valid_in), .input_in(input_in), .psum_in(psum_in),
      .input_out(u_input_out), .valid_out(u_valid_out), .psum_out(u_psum_out),
      .psum_valid(u_psum_valid), .weight_in(weight_in), .weight_shift(weight_shift),
      .weight_out(u_weight_out), .weight_swap(weight_swap), .sat_flag(u_sat_flag));

   typedef struct {
      logic [15:0] w;
      logic [15:0] x;
      logic [31:0] p;
      logic [31:0] exp_s;
      logic [31:0] exp_u;
      logic [31:0] sat_s;
      logic [31:0] sat_u;
   } vec_t;

   vec_t vecs[8];
   int   n_vec = 0;
   int   n_err = 0;
   logic [31:0] exp_stream[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   initial begin
      //          w          x          p              signed         unsigned       sat signed     sat unsigned
      vecs[0] = '{16'h0003, 16'h0004, 32'h0000000A, 32'h00000016, 32'h00000016, 32'h00000016, 32'h00000016};
      vecs[1] = '{16'hFFFD, 16'h0005, 32'h00000000, 32'hFFFFFFF1, 32'h0004FFF1, 32'hFFFFFFF1, 32'h0004FFF1};
      vecs[2] = '{16'hFFFF, 16'h0002, 32'h00000000, 32'hFFFFFFFE, 32'h0001FFFE, 32'hFFFFFFFE, 32'h0001FFFE};
      vecs[3] = '{16'h7FFF, 16'h7FFF, 32'h00000001, 32'h3FFF0002, 32'h3FFF0002, 32'h3FFF0002, 32'h3FFF0002};
      vecs[4] = '{16'h8000, 16'h8000, 32'h00000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
      vecs[5] = '{16'h8000, 16'h0001, 32'h00000000, 32'hFFFF8000, 32'h00008000, 32'hFFFF8000, 32'h00008000};
      vecs[6] = '{16'h0010, 16'h0010, 32'h7FFFFFF0, 32'h800000F0, 32'h800000F0, 32'h7FFFFFFF, 32'h800000F0};
      vecs[7] = '{16'h0002, 16'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0001FFFD, 32'hFFFFFFFD, 32'hFFFFFFFF};

      reset = 1'b1; valid_in = 1'b0; input_in = '0; psum_in = '0;
      weight_in = '0; weight_shift = 1'b0; weight_swap = 1'b0;
      tick(); tick();
      reset = 1'b0;

      // idle after reset: everything stays zero
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("idle a_psum_out", a_psum_out, 32'h0);
         chk("idle a_input_out", 32'(a_input_out), 32'h0);
         chk("idle a_weight_out", 32'(a_weight_out), 32'h0);
         chk("idle a_valid_out", 32'(a_valid_out), 32'h0);
         chk("idle a_psum_valid", 32'(a_psum_valid), 32'h0);
         chk("idle b_psum_valid", 32'(b_psum_valid), 32'h0);
         chk("idle b_psum_out", b_psum_out, 32'h0);
         chk("idle a_sat_flag", 32'(a_sat_flag), 32'h0);
      end

      // table: load weight, swap, one operand, then a bubble
      for (int i = 0; i < 8; i++) begin
         weight_in = vecs[i].w; weight_shift = 1'b1;
         tick();
         weight_shift = 1'b0;
         chk($sformatf("v%0d weight_out", i), 32'(a_weight_out), 32'(vecs[i].w));
         weight_swap = 1'b1;
         tick();
         weight_swap = 1'b0;
         valid_in = 1'b1; input_in = vecs[i].x; psum_in = vecs[i].p;
         tick();
         valid_in = 1'b0; input_in = 16'h1234; psum_in = 32'hDEADBEEF;
         chk($sformatf("v%0d a_psum_out", i), a_psum_out, SAT ? vecs[i].sat_s : vecs[i].exp_s);
         chk($sformatf("v%0d u_psum_out", i), u_psum_out, SAT ? vecs[i].sat_u : vecs[i].exp_u);
         chk($sformatf("v%0d a_psum_valid", i), 32'(a_psum_valid), 32'h1);
         chk($sformatf("v%0d a_valid_out", i), 32'(a_valid_out), 32'h1);
         chk($sformatf("v%0d a_input_out", i), 32'(a_input_out), 32'(vecs[i].x));
         chk($sformatf("v%0d b_psum_valid early", i), 32'(b_psum_valid), 32'h0);
         tick();
         chk($sformatf("v%0d b_psum_out", i), b_psum_out, SAT ? vecs[i].sat_s : vecs[i].exp_s);
         chk($sformatf("v%0d b_psum_valid", i), 32'(b_psum_valid), 32'h1);
         chk($sformatf("v%0d a_psum_valid pulse", i), 32'(a_psum_valid), 32'h0);
         chk($sformatf("v%0d a_psum_out hold", i), a_psum_out, SAT ? vecs[i].sat_s : vecs[i].exp_s);
         chk($sformatf("v%0d a_input_out hold", i), 32'(a_input_out), 32'(vecs[i].x));
         chk($sformatf("v%0d a_valid_out low", i), 32'(a_valid_out), 32'h0);
      end
      chk("a_sat_flag sticky", 32'(a_sat_flag), 32'(SAT));
      chk("u_sat_flag sticky", 32'(u_sat_flag), 32'(SAT));

      // active=2, shadow loads 7 during the stream, swap on op 2
      weight_in = 16'd2; weight_shift = 1'b1;
      tick();
      weight_shift = 1'b0; weight_swap = 1'b1;
      tick();
      weight_swap = 1'b0;
      for (int k = 0; k < 6; k++) exp_stream[k] = (k <= 2) ? 32'd2 : 32'd7;
      for (int k = 0; k < 6; k++) begin
         valid_in = 1'b1; input_in = 16'd1; psum_in = 32'd0;
         weight_shift = (k == 0); weight_in = 16'd7;
         weight_swap = (k == 2);
         tick();
         chk($sformatf("stream%0d a_psum_out", k), a_psum_out, exp_stream[k]);
         chk($sformatf("stream%0d a_psum_valid", k), 32'(a_psum_valid), 32'h1);
         if (k > 0) begin
            chk($sformatf("stream%0d b_psum_out", k), b_psum_out, exp_stream[k-1]);
            chk($sformatf("stream%0d b_psum_valid", k), 32'(b_psum_valid), 32'h1);
         end
      end
      valid_in = 1'b0; weight_shift = 1'b0; weight_swap = 1'b0;
      tick();
      chk("stream b_psum_out last", b_psum_out, exp_stream[5]);

      // same-cycle shift+swap: active takes old shadow 5, shadow takes 9
      weight_in = 16'd5; weight_shift = 1'b1;
      tick();
      weight_in = 16'd9; weight_swap = 1'b1;
      tick();
      weight_shift = 1'b0; weight_swap = 1'b0;
      chk("shift+swap weight_out", 32'(a_weight_out), 32'd9);
      valid_in = 1'b1; input_in = 16'd1; psum_in = 32'd0;
      tick();
      valid_in = 1'b0;
      chk("shift+swap active", a_psum_out, 32'd5);

      // reset with the two-stage pipe full
      valid_in = 1'b1; input_in = 16'd2; psum_in = 32'd1;
      tick();
      input_in = 16'd3;
      tick();
      valid_in = 1'b0;
      chk("pre-reset b_psum_valid", 32'(b_psum_valid), 32'h1);
      chk("pre-reset b_psum_out", b_psum_out, 32'd11);
      reset = 1'b1;
      #1;
      chk("reset b_psum_out", b_psum_out, 32'h0);
      chk("reset b_psum_valid", 32'(b_psum_valid), 32'h0);
      chk("reset a_psum_out", a_psum_out, 32'h0);
      chk("reset a_weight_out", 32'(a_weight_out), 32'h0);
      chk("reset a_valid_out", 32'(a_valid_out), 32'h0);
      chk("reset a_sat_flag", 32'(a_sat_flag), 32'h0);
      tick();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("post-reset b_psum_valid", 32'(b_psum_valid), 32'h0);
         chk("post-reset a_psum_valid", 32'(a_psum_valid), 32'h0);
      end
      valid_in = 1'b1; input_in = 16'd7; psum_in = 32'd0;
      tick();
      valid_in = 1'b0;
      chk("post-reset weight cleared", a_psum_out, 32'h0);
      chk("post-reset a_psum_valid", 32'(a_psum_valid), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
